fetch_queue: RTL and testbench

- Parametrised successor to the single-register fetch stage.
- Decouples PC generation from decode through a DEPTH-entry instruction queue.
- Supports a pipelined, multi-cycle-latency icache with up to MAX_OUTSTANDING requests in flight.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses. Sits between the icache and decode.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_queue.sv | 170 +++++++++++++++++
 tb/tb_fetch_queue.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: queue entry layout, instruction size and
// the RUN/DRAIN state encoding.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int FETCH_XLEN  = 32;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and same-cycle push/pop.
// A pop on an empty queue is ignored; a push into a full queue is illegal.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          empty
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          full;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // NOTE: storage has no reset; entries are only observed after a push has written them.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues icache requests under a credit scheme, queues responses
// for decode, and discards stale responses after a redirect. Optional perf
// counters are enabled with FETCH_PERF_CNT_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            take_branch,
    input  logic [XLEN-1:0] branch_loc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] pc_to_cache,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] instr_from_cache,
    output logic [XLEN-1:0] instr_to_decode,
    output logic [XLEN-1:0] pc_to_decode,
    output logic            valid,
    input  logic            ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_cnt_next;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    fetch_state_e    state;
    fetch_state_e    state_next;
    logic            req_fire;
    logic            resp_keep;
    logic            resp_drop;
    logic            fifo_pop;
    logic            fifo_empty;
    entry_t          push_data;
    entry_t          head;
    logic            unused_branch_bits;

    assign redirect_pc        = {branch_loc[XLEN-1:2], 2'b00};
    assign unused_branch_bits = ^branch_loc[1:0];

    // Slots already filled plus responses still owed must leave room for the new one.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign req_valid   = !reset && !take_branch
                      && (credit_used < (CW+1)'(DEPTH))
                      && (outstanding < CW'(MAX_OUTSTANDING));
    assign req_fire    = req_valid && req_ready;
    assign pc_to_cache = pc_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        drop_cnt_next = drop_cnt;
        if (take_branch) begin
            drop_cnt_next = outstanding - CW'(resp_valid);
        end else if (resp_drop) begin
            drop_cnt_next = drop_cnt - CW'(1);
        end
        state_next = (drop_cnt_next != '0) ? DRAIN : RUN;
    end

    always_comb begin
        resp_keep = 1'b0;
        resp_drop = 1'b0;
        if (resp_valid) begin
            if (take_branch || state == DRAIN) begin
                resp_drop = 1'b1;
            end else begin
                resp_keep = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg      <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_valid);
            drop_cnt    <= drop_cnt_next;
            if (take_branch) begin
                pc_reg  <= redirect_pc;
                resp_pc <= redirect_pc;
            end else begin
                if (req_fire) begin
                    pc_reg <= pc_reg + XLEN'(INSTR_BYTES);
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + XLEN'(INSTR_BYTES);
                end
            end
        end
    end

    assign push_data = '{pc: resp_pc, instr: instr_from_cache};
    assign fifo_pop  = valid && ready && !take_branch;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (resp_keep),
        .push_data (push_data),
        .pop       (fifo_pop),
        .flush     (take_branch),
        .head      (head),
        .count     (count),
        .empty     (fifo_empty)
    );

    // Head fields are forced to zero while empty so decode never sees stale storage.
    assign valid           = !reset && !fifo_empty;
    assign instr_to_decode = valid ? head.instr : '0;
    assign pc_to_decode    = valid ? head.pc    : '0;

    a_resp_has_owner: assert property (@(posedge clk) disable iff (reset)
                                       resp_valid |-> (outstanding != '0));

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (resp_keep && perf_fetched != '1) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (resp_drop && perf_dropped != '1) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if (valid && !ready && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a table of per-cycle vectors against a
// 1-cycle icache, then directed sequences for backpressure, latency and redirects.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        take_branch;
    logic [31:0] branch_loc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] pc_to_cache;
    logic        resp_valid;
    logic [31:0] instr_from_cache;
    logic [31:0] instr_to_decode;
    logic [31:0] pc_to_decode;
    logic        valid;
    logic        ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN            (32),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .take_branch      (take_branch),
        .branch_loc       (branch_loc),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .pc_to_cache      (pc_to_cache),
        .resp_valid       (resp_valid),
        .instr_from_cache (instr_from_cache),
        .instr_to_decode  (instr_to_decode),
        .pc_to_decode     (pc_to_decode),
        .valid            (valid),
        .ready            (ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_dropped     (perf_dropped),
        .perf_stall       (perf_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    int fires    = 0;

    // icache model: a request accepted in cycle c is answered in cycle c+lat,
    // in order; the returned instruction is the bitwise inverse of its PC.
    typedef struct {
        logic [31:0] pc;
        int          due;
    } cache_req_t;
    cache_req_t pend[$];

    typedef struct {
        logic        tb;
        logic [31:0] loc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_dpc;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_resp();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            resp_valid       = 1'b1;
            instr_from_cache = ~pend[0].pc;
        end else begin
            resp_valid       = 1'b0;
            instr_from_cache = '0;
        end
    endtask

    task automatic tick();
        logic        fire;
        logic        took;
        logic [31:0] pc;
        #1;
        fire = req_valid && req_ready;
        took = resp_valid;
        pc   = pc_to_cache;
        @(posedge clk);
        cyc++;
        if (reset) begin
            pend.delete();
        end else begin
            if (took && pend.size() > 0) void'(pend.pop_front());
            if (fire) begin
                pend.push_back('{pc: pc, due: cyc - 1 + lat});
                fires++;
            end
        end
        @(negedge clk);
        drive_resp();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        take_branch = 1'b0;
        branch_loc  = '0;
        ready       = 1'b0;
        req_ready   = 1'b1;
        tick();
        tick();
        #1;
        check("reset req_valid", {31'b0, req_valid}, 32'd0);
        check("reset valid", {31'b0, valid}, 32'd0);
        check("reset pc_to_decode", pc_to_decode, 32'h0);
        check("reset instr_to_decode", instr_to_decode, 32'h0);
        reset = 1'b0;
    endtask

    // Waits (bounded) for the queue head, then checks its PC and instruction.
    task automatic expect_next(input string name, input logic [31:0] exp_pc);
        int n = 0;
        #1;
        while (!valid && n < 20) begin
            tick();
            #1;
            n++;
        end
        check($sformatf("%s valid", name), {31'b0, valid}, 32'd1);
        if (valid) begin
            check($sformatf("%s pc", name), pc_to_decode, exp_pc);
            check($sformatf("%s instr", name), instr_to_decode, ~exp_pc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_dec;
        int maxf;

        resp_valid       = 1'b0;
        instr_from_cache = '0;

        // Rows 0-5: streaming from reset; row 6: redirect to 0x102 while a
        // response arrives and decode pops; rows 7-10: restart at 0x100.
        //           tb    loc       rdy   req   pc_to_cache  valid pc_to_decode
        vecs[0]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h0,       1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h4,       1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h8,       1'b1, 32'h0};
        vecs[3]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'hC,       1'b1, 32'h4};
        vecs[4]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h10,      1'b1, 32'h8};
        vecs[5]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h14,      1'b1, 32'hC};
        vecs[6]  = '{1'b1, 32'h102,  1'b1, 1'b0, 32'h0,       1'b1, 32'h10};
        vecs[7]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h100,     1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h104,     1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h108,     1'b1, 32'h100};
        vecs[10] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h10C,     1'b1, 32'h104};

        do_reset();
        lat = 1;
        for (int i = 0; i < 11; i++) begin
            take_branch = vecs[i].tb;
            branch_loc  = vecs[i].loc;
            ready       = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d req_valid", i), {31'b0, req_valid}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) check($sformatf("vec%0d pc_to_cache", i), pc_to_cache, vecs[i].e_pc);
            check($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d pc_to_decode", i), pc_to_decode, vecs[i].e_dpc);
                check($sformatf("vec%0d instr", i), instr_to_decode, ~vecs[i].e_dpc);
            end
            tick();
        end
        take_branch = 1'b0;

        // Backpressure: four entries fill the queue, requests stop, then drain.
        do_reset();
        lat = 1;
        repeat (5) tick();
        #1;
        check("full req_valid", {31'b0, req_valid}, 32'd0);
        check("full valid", {31'b0, valid}, 32'd1);
        check("full head pc", pc_to_decode, 32'h0);
        repeat (2) tick();
        #1;
        check("full req_valid held", {31'b0, req_valid}, 32'd0);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("drain%0d pc", i), pc_to_decode, 32'(4 * i));
            if (i == 0) check("drain0 req_valid", {31'b0, req_valid}, 32'd0);
            if (i == 1) begin
                check("drain1 req_valid", {31'b0, req_valid}, 32'd1);
                check("drain1 pc_to_cache", pc_to_cache, 32'h10);
            end
            tick();
        end

        // Response two cycles after the request: two credits give two requests
        // every three cycles.
        do_reset();
        lat   = 2;
        ready = 1'b1;
        fires = 0;
        maxf  = 0;
        n_dec = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (valid) begin
                check($sformatf("lat dec%0d pc", n_dec), pc_to_decode, 32'(4 * n_dec));
                n_dec++;
            end
            tick();
            if (pend.size() > maxf) maxf = pend.size();
        end
        check("lat max in flight", 32'(maxf), 32'd2);
        check("lat requests in 12 cycles", 32'(fires), 32'd8);
        check("lat decoded in 12 cycles", 32'(n_dec), 32'd6);

        // Redirect with two queued entries and two responses in flight.
        do_reset();
        lat = 3;
        repeat (6) tick();
        take_branch = 1'b1;
        branch_loc  = 32'h100;
        #1;
        check("redir req_valid same cycle", {31'b0, req_valid}, 32'd0);
        check("redir valid before", {31'b0, valid}, 32'd1);
        tick();
        take_branch = 1'b0;
        #1;
        check("redir valid after", {31'b0, valid}, 32'd0);
        check("redir req_valid no credit", {31'b0, req_valid}, 32'd0);
        tick();
        #1;
        check("redir req_valid restart", {31'b0, req_valid}, 32'd1);
        check("redir pc_to_cache", pc_to_cache, 32'h100);
        ready = 1'b1;
        expect_next("redir first", 32'h100);
        tick();
        expect_next("redir second", 32'h104);

        // Reset with a full queue.
        do_reset();
        lat = 1;
        repeat (6) tick();
        #1;
        check("rstfull valid before", {31'b0, valid}, 32'd1);
        check("rstfull req_valid before", {31'b0, req_valid}, 32'd0);
        reset = 1'b1;
        #1;
        check("rstfull valid in reset", {31'b0, valid}, 32'd0);
        tick();
        #1;
        check("rstfull valid next", {31'b0, valid}, 32'd0);
        check("rstfull req_valid next", {31'b0, req_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("rstfull restart req_valid", {31'b0, req_valid}, 32'd1);
        check("rstfull restart pc", pc_to_cache, 32'h0);
        ready = 1'b1;
        expect_next("rstfull first", 32'h0);

        // Reset while draining stale responses after a redirect.
        do_reset();
        lat = 3;
        repeat (6) tick();
        take_branch = 1'b1;
        branch_loc  = 32'h200;
        tick();
        take_branch = 1'b0;
        reset       = 1'b1;
        #1;
        check("rstdrain req_valid in reset", {31'b0, req_valid}, 32'd0);
        tick();
        #1;
        check("rstdrain valid next", {31'b0, valid}, 32'd0);
        check("rstdrain req_valid next", {31'b0, req_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("rstdrain restart pc", pc_to_cache, 32'h0);
        ready = 1'b1;
        expect_next("rstdrain first", 32'h0);
        tick();
        expect_next("rstdrain second", 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
